md_unit_iter: RTL and testbench
===============================

Name: md_unit_iter

Overview:
- Parametrised next-generation HI/LO multiply/divide unit for the pipelined MIPS core; sits in the E stage beside the ALU.
- Multiply latency is configurable through a result-delay pipeline.
- Divide is a true iterative radix-2 restoring divider, one quotient bit per cycle, so latency is data-width dependent.
- Stalls the pipeline only when a HI/LO-touching instruction arrives while an operation is in flight, and supports squashing an issuing op on exception.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (even, >=8).
- MULT_LAT, 5, cycles from mult issue to HI/LO valid (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 treated as none.
- md_flush  input  1  squash the op presented this cycle (exception/branch kill).
- rs  input  WIDTH  source operand A.
- rt  input  WIDTH  source operand B.
- md_busy  output  1  registered; high while a mult/div is in flight.
- md_stall  output  1  combinational; md_busy AND md_op != none.
- md_out  output  WIDTH  combinational; HI for mfhi, LO for mflo, else 0.

Behaviour:
- Reset (synchronous, active-high) clears HI, LO, counter, divider registers and md_busy, and returns the FSM to IDLE. Reset mid-operation abandons the operation, and HI/LO read 0 afterwards.
- An op is accepted only when state is IDLE and md_flush=0. While busy, ops are not accepted; the core holds the op because md_stall=1.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + mult/multu: capture the full 2*WIDTH product into a temp register; set cnt=MULT_LAT-1, md_busy=1, go to MUL.
  - If MULT_LAT=1, go directly to writeback on the next edge.
- MUL: decrement cnt; at cnt=0 write {HI,LO}=temp, clear md_busy, return to IDLE.
  - mult issued at edge N makes HI/LO valid and md_busy=0 after edge N+MULT_LAT.
- IDLE + div/divu: load |rs| and |rt| (magnitudes for signed, raw for unsigned) and record the sign of the quotient and remainder; cnt=WIDTH; md_busy=1; go to DIV.
- DIV: per cycle, shift partial remainder left by 1 with the next dividend bit; if remainder>=divisor, subtract and set quotient bit to 1. After WIDTH iterations go to FIX.
- FIX: negate the quotient if the operand signs differ (signed only); give the remainder the sign of rs; write LO=quotient, HI=remainder; clear md_busy; return to IDLE. Total divide latency is WIDTH+1 cycles.
- Divide by zero: LO=all ones, HI=rs, for both signed and unsigned. Latency is unchanged.
- Signed overflow (most-negative / -1): LO=most-negative, HI=0.
- mthi/mtlo in IDLE: write HI or LO from rs at the edge; the other register is unchanged; md_busy stays 0.
- mfhi/mflo in IDLE: md_out shows the current HI/LO in the same cycle; no state change.
- mfhi/mflo while busy: md_stall=1, and md_out is don't-care until the stall releases.
- md_flush=1 with any op in IDLE: no state change and no HI/LO write.
- md_flush has no effect on an operation already in flight, since it is committed.
- Back-to-back: the cycle md_busy falls, a new op is accepted on the next edge with no bubble.
- Ops 9-12 behave as none unless the optional feature is compiled in.

Optional Feature:
- Macro: MD_MACC_EN.
- Defined:
  - madd/maddu: {HI,LO} += product.
  - msub/msubu: {HI,LO} -= product.
  - Signed variants use a signed product, unsigned variants an unsigned product. Accumulation is modulo 2^(2*WIDTH).
  - The HI/LO snapshot is taken at issue, and the result is written at the end of MUL with mult latency.
- Undefined: ops 9-12 are treated as none: no stall, no busy, no HI/LO write.

Test Plan:
- mult rs=0xFFFFFFFE rt=0x00000003, then mfhi/mflo after md_busy falls -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; md_busy high exactly 5 cycles.
- multu rs=0xFFFFFFFF rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div rs=-7 (0xFFFFFFF9) rt=2, then immediate mflo -> md_stall=1 for 33 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu rs=100 rt=0 -> LO=0xFFFFFFFF, HI=100; then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0x1234 and mtlo 0x5678 back-to-back, then mflo -> md_out=0x5678, HI=0x1234, md_busy never set; divu issued with md_flush=1 -> md_busy stays 0.
- Reset asserted on the 10th cycle of a div -> next cycle md_busy=0, HI=LO=0; MD_MACC_EN build: mult 3*4, then madd 2*5 -> LO=22, HI=0.

Source files
------------

// File: rtl/md_unit_iter.sv
// HI/LO multiply/divide unit: pipelined-latency multiply and radix-2 restoring divide.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) under `define MD_MACC_EN.
module md_unit_iter #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       md_op,
   input  logic             md_flush,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             md_busy,
   output logic             md_stall,
   output logic [WIDTH-1:0] md_out
);

   localparam int MAXC = (WIDTH > MULT_LAT) ? WIDTH : MULT_LAT;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int W2   = 2 * WIDTH;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   state_t           r_state, w_state_n;
   logic [WIDTH-1:0] r_hi, w_hi_n;
   logic [WIDTH-1:0] r_lo, w_lo_n;
   logic [CW-1:0]    r_cnt, w_cnt_n;
   logic [W2-1:0]    r_temp, w_temp_n;
   logic [WIDTH-1:0] r_rem, w_rem_n;
   logic [WIDTH-1:0] r_quo, w_quo_n;
   logic [WIDTH-1:0] r_dvsr, w_dvsr_n;
   logic             r_negq, w_negq_n;
   logic             r_negr, w_negr_n;
   logic             r_dz, w_dz_n;
   logic             r_busy, w_busy_n;

   logic             w_is_mul, w_is_div, w_is_macc;
   logic             w_psgn, w_dsgn, w_op_valid, w_accept;
   logic [W2-1:0]    w_a, w_b, w_prod, w_mul_res;
   logic [WIDTH-1:0] w_abs_rs, w_abs_rt;
   logic [WIDTH:0]   w_sh;
   logic             w_ge;
   logic [WIDTH-1:0] w_sub;

   assign w_is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
   assign w_is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
   assign w_dsgn   = (md_op == OP_DIV);

`ifdef MD_MACC_EN
   logic w_acc_sub;
   assign w_is_macc = (md_op >= OP_MADD) && (md_op <= OP_MSUBU);
   assign w_acc_sub = (md_op == OP_MSUB) || (md_op == OP_MSUBU);
   assign w_psgn    = (md_op == OP_MULT) || (md_op == OP_MADD) ||
                      (md_op == OP_MSUB);
`else
   assign w_is_macc = 1'b0;
   assign w_psgn    = (md_op == OP_MULT);
`endif

   assign w_op_valid = w_is_mul || w_is_div || w_is_macc ||
                       (md_op == OP_MFHI) || (md_op == OP_MFLO) ||
                       (md_op == OP_MTHI) || (md_op == OP_MTLO);

   assign w_accept = (r_state == S_IDLE) && !md_flush;

   // Sign-extended operands give the signed product modulo 2^(2*WIDTH)
   assign w_a    = {{WIDTH{w_psgn & rs[WIDTH-1]}}, rs};
   assign w_b    = {{WIDTH{w_psgn & rt[WIDTH-1]}}, rt};
   assign w_prod = w_a * w_b;

`ifdef MD_MACC_EN
   assign w_mul_res = !w_is_macc ? w_prod :
                      w_acc_sub  ? ({r_hi, r_lo} - w_prod) :
                                   ({r_hi, r_lo} + w_prod);
`else
   assign w_mul_res = w_prod;
`endif

   assign w_abs_rs = (w_dsgn && rs[WIDTH-1]) ? -rs : rs;
   assign w_abs_rt = (w_dsgn && rt[WIDTH-1]) ? -rt : rt;

   assign w_sh  = {r_rem, r_quo[WIDTH-1]};
   assign w_ge  = (w_sh >= {1'b0, r_dvsr});
   assign w_sub = w_sh[WIDTH-1:0] - r_dvsr;

   always_comb begin
      w_state_n = r_state;
      w_hi_n    = r_hi;
      w_lo_n    = r_lo;
      w_cnt_n   = r_cnt;
      w_temp_n  = r_temp;
      w_rem_n   = r_rem;
      w_quo_n   = r_quo;
      w_dvsr_n  = r_dvsr;
      w_negq_n  = r_negq;
      w_negr_n  = r_negr;
      w_dz_n    = r_dz;
      w_busy_n  = r_busy;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_is_mul || w_is_macc) begin
                  w_temp_n  = w_mul_res;
                  w_cnt_n   = CW'(MULT_LAT - 1);
                  w_busy_n  = 1'b1;
                  w_state_n = S_MUL;
               end else if (w_is_div) begin
                  w_rem_n   = '0;
                  w_quo_n   = w_abs_rs;
                  w_dvsr_n  = w_abs_rt;
                  w_negq_n  = w_dsgn && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                  w_negr_n  = w_dsgn && rs[WIDTH-1];
                  w_dz_n    = (rt == '0);
                  w_cnt_n   = CW'(WIDTH);
                  w_busy_n  = 1'b1;
                  w_state_n = S_DIV;
               end else if (md_op == OP_MTHI) begin
                  w_hi_n = rs;
               end else if (md_op == OP_MTLO) begin
                  w_lo_n = rs;
               end
            end
         end
         S_MUL: begin
            if (r_cnt == '0) begin
               {w_hi_n, w_lo_n} = r_temp;
               w_busy_n  = 1'b0;
               w_state_n = S_IDLE;
            end else begin
               w_cnt_n = r_cnt - 1'b1;
            end
         end
         S_DIV: begin
            w_rem_n = w_ge ? w_sub : w_sh[WIDTH-1:0];
            w_quo_n = {r_quo[WIDTH-2:0], w_ge};
            w_cnt_n = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) w_state_n = S_FIX;
         end
         S_FIX: begin
            w_lo_n    = r_dz   ? '1 :
                        r_negq ? -r_quo : r_quo;
            w_hi_n    = r_negr ? -r_rem : r_rem;
            w_busy_n  = 1'b0;
            w_state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
         r_temp  <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvsr  <= '0;
         r_negq  <= 1'b0;
         r_negr  <= 1'b0;
         r_dz    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_hi    <= w_hi_n;
         r_lo    <= w_lo_n;
         r_cnt   <= w_cnt_n;
         r_temp  <= w_temp_n;
         r_rem   <= w_rem_n;
         r_quo   <= w_quo_n;
         r_dvsr  <= w_dvsr_n;
         r_negq  <= w_negq_n;
         r_negr  <= w_negr_n;
         r_dz    <= w_dz_n;
         r_busy  <= w_busy_n;
      end
   end

   assign md_busy  = r_busy;
   assign md_stall = r_busy && w_op_valid;
   assign md_out   = (md_op == OP_MFHI) ? r_hi :
                     (md_op == OP_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_md_unit_iter.sv
// Directed bench for md_unit_iter with HI/LO scoreboard queues.
// Define MD_MACC_EN to exercise the multiply-accumulate ops.
module tb_md_unit_iter;

   localparam int W = 32;

   localparam logic [3:0] NONE  = 4'd0;
   localparam logic [3:0] MULT  = 4'd1;
   localparam logic [3:0] MULTU = 4'd2;
   localparam logic [3:0] DIV   = 4'd3;
   localparam logic [3:0] DIVU  = 4'd4;
   localparam logic [3:0] MFHI  = 4'd5;
   localparam logic [3:0] MFLO  = 4'd6;
   localparam logic [3:0] MTHI  = 4'd7;
   localparam logic [3:0] MTLO  = 4'd8;
   localparam logic [3:0] MADD  = 4'd9;
   localparam logic [3:0] MSUB  = 4'd11;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   md_op;
   logic         md_flush;
   logic [W-1:0] rs, rt;
   logic         md_busy, md_stall;
   logic [W-1:0] md_out;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] hq[$];
   logic [W-1:0] lq[$];

   md_unit_iter #(.WIDTH(W), .MULT_LAT(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .md_op    (md_op),
      .md_flush (md_flush),
      .rs       (rs),
      .rt       (rt),
      .md_busy  (md_busy),
      .md_stall (md_stall),
      .md_out   (md_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] eh, input logic [W-1:0] el);
      hq.push_back(eh);
      lq.push_back(el);
   endtask

   task automatic read_back(input string tag);
      logic [W-1:0] eh, el;
      eh = hq.pop_front();
      el = lq.pop_front();
      md_op = MFLO;
      #1;
      chk({tag, " lo"}, 64'(md_out), 64'(el));
      md_op = MFHI;
      #1;
      chk({tag, " hi"}, 64'(md_out), 64'(eh));
      md_op = NONE;
   endtask

   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input int ecyc);
      int n = 0;
      push(eh, el);
      md_op = op;
      rs = a;
      rt = b;
      tick();
      md_op = MFLO;
      #1;
      while (md_stall && n < 200) begin
         n++;
         @(posedge clk);
         #2;
      end
      chk({tag, " stall"}, 64'(n), 64'(ecyc));
      read_back(tag);
      tick();
   endtask

   initial begin
      int n;
      reset = 1'b1;
      md_op = NONE;
      md_flush = 1'b0;
      rs = '0;
      rt = '0;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst busy", 64'(md_busy), 64'd0);
      chk("rst stall", 64'(md_stall), 64'd0);
      push('0, '0);
      read_back("rst");
      tick();

      run_op("mult", MULT, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      run_op("multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 5);
      run_op("mult_nn", MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'd15, 5);
      run_op("div", DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      run_op("div_pn", DIV, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 33);
      run_op("divu_big", DIVU, 32'hFFFFFFF9, 32'h2, 32'h1, 32'h7FFFFFFC, 33);
      run_op("divu_z", DIVU, 32'd100, 32'h0, 32'd100, 32'hFFFFFFFF, 33);
      run_op("div_z", DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 33);
      run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);

      md_op = MTHI;
      rs = 32'h1234;
      tick();
      chk("mthi busy", 64'(md_busy), 64'd0);
      md_op = MTLO;
      rs = 32'h5678;
      tick();
      chk("mtlo busy", 64'(md_busy), 64'd0);
      push(32'h1234, 32'h5678);
      read_back("mtx");
      tick();

      md_op = DIVU;
      rs = 32'd100;
      rt = 32'd0;
      md_flush = 1'b1;
      tick();
      md_flush = 1'b0;
      md_op = NONE;
      chk("flush busy", 64'(md_busy), 64'd0);
      tick();
      chk("flush busy2", 64'(md_busy), 64'd0);
      push(32'h1234, 32'h5678);
      read_back("flush");
      tick();

      md_op = MULT;
      rs = 32'd3;
      rt = 32'd4;
      tick();
      md_op = NONE;
`ifndef MD_MACC_EN
      md_op = MADD;
      #1;
      chk("op9 nostall", 64'(md_stall), 64'd0);
      md_op = NONE;
`endif
      n = 0;
      while (md_busy && n < 50) begin
         n++;
         tick();
      end
      chk("b2b first", 64'(n), 64'd5);
      md_op = MULTU;
      rs = 32'd5;
      rt = 32'd6;
      tick();
      md_op = NONE;
      chk("b2b busy", 64'(md_busy), 64'd1);
      n = 0;
      while (md_busy && n < 50) begin
         n++;
         tick();
      end
      chk("b2b second", 64'(n), 64'd5);
      push(32'h0, 32'd30);
      read_back("b2b");
      tick();

`ifdef MD_MACC_EN
      run_op("m34", MULT, 32'd3, 32'd4, 32'h0, 32'd12, 5);
      run_op("madd", MADD, 32'd2, 32'd5, 32'h0, 32'd22, 5);
      run_op("msub", MSUB, 32'd3, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFF8, 5);
`else
      md_op = MADD;
      rs = 32'd2;
      rt = 32'd5;
      tick();
      md_op = NONE;
      chk("madd off busy", 64'(md_busy), 64'd0);
      push(32'h0, 32'd30);
      read_back("madd off");
      tick();
`endif

      md_op = DIV;
      rs = 32'hFFFFFFF9;
      rt = 32'd2;
      tick();
      md_op = NONE;
      repeat (8) tick();
      chk("pre-rst busy", 64'(md_busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst busy", 64'(md_busy), 64'd0);
      push('0, '0);
      read_back("midrst");
      tick();
      chk("post-rst busy", 64'(md_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
